uart_rx_controller: RTL
=======================

# uart_rx_controller

Serial receive controller for the UART: the receiving end of the frame produced by the transmit controller. The frame is start bit (0), 8 data bits LSB first, even parity bit, and stop bit (1). The block synchronises the asynchronous serial line, detects the start edge and samples each bit at mid-bit. It delivers the received byte with a one-cycle valid strobe plus parity and framing error flags. It sits between the external RX pin and the receive data consumer (register interface or FIFO).

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and ≥ 4.
- clk  input  1  system clock; all flops on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- rx_data  output  8  last received byte; updated only when rx_valid pulses.
- rx_valid  output  1  one-cycle pulse: a complete frame has been received.
- parity_err  output  1  even-parity mismatch on the last frame; updated with rx_valid, held until the next rx_valid.
- frame_err  output  1  stop bit sampled 0 on the last frame; updated with rx_valid, held until the next rx_valid.
- busy  output  1  high in every state except IDLE.

## Operation
- Synchroniser: two flops on rx; reset value 1; the output is rx_s. All decisions use rx_s only.
- Counter: clk-cycle counter, width $clog2(CLKS_PER_BIT), cleared on every state entry. Bit counter: 0..7.
- States:
  - IDLE: if rx_s == 0, go to START.
  - START: when counter reaches CLKS_PER_BIT/2−1, sample rx_s.
    - rx_s == 1: false start. Go to IDLE; no rx_valid, no error flags touched.
    - rx_s == 0: go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s and shift it into the internal shift register from the MSB end (LSB first on the line). After the 8th sample, go to PARITY.
  - PARITY: after CLKS_PER_BIT cycles, sample the parity bit. Mismatch = XOR(shift reg) ^ parity bit ≠ 0.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit. On that edge:
    - load rx_data from the shift register;
    - set parity_err from the parity check;
    - set frame_err = ~rx_s;
    - pulse rx_valid.
    - Next state: IDLE if the stop bit is 1, WAIT_IDLE if it is 0.
  - WAIT_IDLE: stay until rx_s == 1, then go to IDLE. This prevents a held-low line or break from being re-read as frames.
- Frames with errors are still delivered: rx_valid is asserted and the error flags are set.
- Reset, including mid-frame: immediately return to IDLE. Discard the partial frame; no rx_valid.
- Reset values: rx_data 0x00, rx_valid 0, parity_err 0, frame_err 0, busy 0, synchroniser flops 1.

## Timing
- Let E0 be the clk edge at which the first synchroniser flop captures rx = 0.
  - rx_s goes low after E1.
  - The state register enters START at E2.
- Start-bit sample at edge E2 + CLKS_PER_BIT/2.
- Each following sample is exactly CLKS_PER_BIT edges later. The stop sample is at E2 + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT.
- rx_valid is high for exactly the one cycle after the stop-sample edge. With CLKS_PER_BIT = 16 this is the cycle after E170.
- Back-to-back frames: IDLE is entered on the edge after the stop sample. A start edge arriving at the end of the stop bit is therefore caught with no lost frame. Successive rx_valid pulses are 11·CLKS_PER_BIT cycles apart.
- No backpressure: the consumer must take rx_data within 11·CLKS_PER_BIT cycles. rx_data is overwritten at the next rx_valid.

## Structure
- Shared package uart_pkg holds:
  - the state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE;
  - DATA_BITS = 8;
  - PARITY_EVEN;
  - the frame bit-count constant shared with the transmit controller.
- One sub-module: uart_sync2, a two-flop synchroniser with a parameterised reset value. It is reused for any other asynchronous UART input.

## Test plan
- Frame 0xA5, parity 0, stop 1, CLKS_PER_BIT = 16 → rx_data = 0xA5. rx_valid high for exactly one cycle after E170; parity_err = 0, frame_err = 0; busy falls the next cycle.
- Frame 0x01 with parity bit 0 (correct is 1) → rx_valid pulses, rx_data = 0x01, parity_err = 1, frame_err = 0.
- Frame 0x3C with stop bit 0, then rx held low for 40 cycles → one rx_valid with rx_data = 0x3C and frame_err = 1. busy stays high until rx returns high; no second rx_valid.
- rx low glitch of 4 cycles, then high → no rx_valid; state returns to IDLE after the START sample; flags unchanged.
- reset asserted for 1 cycle during the 3rd data bit → all outputs at reset values, no rx_valid. A following full frame 0x5A is received correctly with no errors.
- Frames 0xFF then 0x00 with no idle gap → two rx_valid pulses exactly 176 cycles apart, with rx_data 0xFF then 0x00 and both error flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and receiver state encoding
package uart_pkg;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 1 + DATA_BITS + 1 + 1;
  localparam logic PARITY_EVEN = 1'b0;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} uart_state_e;
endpackage

// File: rtl/uart_rx_controller_if.sv
// uart_rx_controller_if: serial line in, received byte and status out
interface uart_rx_controller_if;
  import uart_pkg::*;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
  modport slave (input rx, output rx_data, rx_valid, parity_err, frame_err, busy);
  modport master (output rx, input rx_data, rx_valid, parity_err, frame_err, busy);
endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous input
module uart_sync2 #(parameter logic RST_VAL = 1'b1) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic ff1_q, ff2_q;
  // two-stage capture to settle metastability before use
  always_ff @(posedge clk or posedge reset)
    if (reset) {ff2_q, ff1_q} <= {2{RST_VAL}};
    else {ff2_q, ff1_q} <= {ff1_q, d_i};
  assign q_o = ff2_q;
endmodule

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: 8E1 UART receiver with mid-bit sampling and error flags
module uart_rx_controller
  import uart_pkg::*;
#(parameter int CLKS_PER_BIT = 16) (
  input logic                  clk,
  input logic                  reset,
  uart_rx_controller_if.slave  bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d;
  logic rx_s;
  uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d_i(bus.rx), .q_o(rx_s));
  // next state: walk the frame, sampling rx_s at mid-bit, deliver on the stop sample
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    par_d = par_q;
    data_d = data_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        bit_d = '0;
        if (!rx_s) state_d = START;
      end
      START: if (cnt_q == HALF) state_d = rx_s ? IDLE : DATA;
      DATA: if (cnt_q == LAST) begin
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) state_d = PARITY;
      end
      PARITY: if (cnt_q == LAST) begin
        par_d = (^{shift_q, rx_s}) != PARITY_EVEN;
        state_d = STOP;
      end
      STOP: if (cnt_q == LAST) begin
        data_d = shift_q;
        perr_d = par_q;
        ferr_d = ~rx_s;
        valid_d = 1'b1;
        state_d = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == IDLE || state_d != state_q || cnt_q == LAST) cnt_d = '0;
  end
  // state and datapath registers; reset drops any partial frame
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      par_q <= 1'b0;
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      par_q <= par_d;
      data_q <= data_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      valid_q <= valid_d;
    end
  assign bus.rx_data = data_q;
  assign bus.rx_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy = state_q != IDLE;
endmodule
